hit_address_readout: RTL and testbench

- Reader counterpart of the hit-map storage block, which sets one bit per received address in a dual-port block-RAM bitmap.
- Scans the bitmap row by row through one RAM port and emits the address of every set bit as a stream, lowest address first.
- Valid/ready handshake on the stream; can optionally zero each row after reading it.
- Sits between the bitmap RAM and downstream hit consumers (e.g. a track/pattern lookup).

---
 rtl/hit_address_readout_pkg.sv | 34 +++
 rtl/hit_address_readout_lowest_set_bit_encoder.sv | 23 ++
 rtl/hit_address_readout.sv | 151 +++++++++++++++
 tb/tb_hit_address_readout.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hit_address_readout_pkg.sv
// Shared definitions for the hit-map bitmap: RAM geometry, reader FSM states
// and the {row, column} split of a hit address used by both writer and reader.
package hit_address_readout_pkg;

  localparam int WORDLENGTH     = 16;
  localparam int MEMNROWS       = 16;
  localparam int ROWINDEXBITS   = 4;
  localparam int COLINDEXBITS   = 4;
  localparam int READ_LATENCY   = 1;
  localparam int HITADDRESSBITS = ROWINDEXBITS + COLINDEXBITS;
  localparam int HITCOUNTBITS   = HITADDRESSBITS + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    SCAN  = 3'd3,
    DONE  = 3'd4
  } stateT;

  typedef struct packed {
    logic [ROWINDEXBITS-1:0] row;
    logic [COLINDEXBITS-1:0] column;
  } hitAddressT;

  function automatic hitAddressT makeHitAddress(input logic [ROWINDEXBITS-1:0] row,
                                                input logic [COLINDEXBITS-1:0] column);
    hitAddressT address;
    address.row    = row;
    address.column = column;
    return address;
  endfunction

endpackage

// File: rtl/hit_address_readout_lowest_set_bit_encoder.sv
// Combinational priority encoder: index of the lowest set bit plus an any-set flag.
module lowest_set_bit_encoder #(
  parameter int WIDTH     = 16,
  parameter int INDEXBITS = 4
) (
  input  logic [WIDTH-1:0]     bits,
  output logic [INDEXBITS-1:0] index,
  output logic                 anySet
);

  // Walking from the top down lets the lowest set bit win the last assignment.
  always_comb begin
    index  = '0;
    anySet = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (bits[i]) begin
        index  = INDEXBITS'(i);
        anySet = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hit_address_readout.sv
// Scans the hit bitmap row by row and streams the {row, bit} address of every
// set bit, lowest address first, optionally zeroing each row after it is read.
module hit_address_readout
  import hit_address_readout_pkg::*;
(
  input  logic                      clock,
  input  logic                      resetN,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      clearAfterRead,
  output logic                      busy,
  output logic                      done,
  output logic [ROWINDEXBITS-1:0]   memAddress,
  input  logic [WORDLENGTH-1:0]     memData,
  output logic                      memWriteEnable,
  output logic [WORDLENGTH-1:0]     memWriteData,
  output logic [HITADDRESSBITS-1:0] outAddress,
  output logic                      outValid,
  input  logic                      outReady,
  output logic [HITCOUNTBITS-1:0]   hitCount,
  output logic [2:0]                debugState
);

  localparam int WAITBITS = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  stateT                   state;
  logic [ROWINDEXBITS-1:0] row;
  logic [WORDLENGTH-1:0]   rowBits;
  logic                    rowHadHit;
  logic                    clearLatched;
  logic [WAITBITS-1:0]     waitCount;
  hitAddressT              outHit;
  logic                    writeBack;

  logic [WORDLENGTH-1:0]   nextRowBits;
  logic [WORDLENGTH-1:0]   clearMask;
  logic [COLINDEXBITS-1:0] nextIndex;
  logic                    nextAny;
  logic                    accept;
  logic                    lastWait;

  // Stream handshake: outAddress transfers on a rising clock edge where outValid
  // and outReady are both high; while outValid is high and outReady low, outAddress holds.
  always_comb begin
    clearMask   = WORDLENGTH'(1) << outHit.column;
    accept      = outValid && outReady;
    lastWait    = (state == WAIT) && (waitCount == '0);
    nextRowBits = rowBits;
    if (lastWait) begin
      nextRowBits = memData;
    end else if (state == SCAN && accept) begin
      nextRowBits = rowBits & ~clearMask;
    end
  end

  lowest_set_bit_encoder #(
    .WIDTH    (WORDLENGTH),
    .INDEXBITS(COLINDEXBITS)
  ) u_encoder (
    .bits  (nextRowBits),
    .index (nextIndex),
    .anySet(nextAny)
  );

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state        <= IDLE;
      row          <= '0;
      rowBits      <= '0;
      rowHadHit    <= 1'b0;
      clearLatched <= 1'b0;
      waitCount    <= '0;
      outHit       <= '0;
      outValid     <= 1'b0;
      writeBack    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      hitCount     <= '0;
    end else begin
      done      <= 1'b0;
      writeBack <= 1'b0;
      if (abort && state != IDLE) begin
        state    <= IDLE;
        busy     <= 1'b0;
        outValid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              row          <= '0;
              hitCount     <= '0;
              clearLatched <= clearAfterRead;
              busy         <= 1'b1;
              state        <= ISSUE;
            end
          end
          ISSUE: begin
            waitCount <= WAITBITS'(READ_LATENCY - 1);
            state     <= WAIT;
          end
          WAIT: begin
            if (lastWait) begin
              rowBits   <= nextRowBits;
              rowHadHit <= nextAny;
              outValid  <= nextAny;
              outHit    <= makeHitAddress(row, nextIndex);
              state     <= SCAN;
            end else begin
              waitCount <= waitCount - WAITBITS'(1);
            end
          end
          SCAN: begin
            if (rowBits == '0) begin
              if (row == ROWINDEXBITS'(MEMNROWS - 1)) begin
                done  <= 1'b1;
                state <= DONE;
              end else begin
                row   <= row + ROWINDEXBITS'(1);
                state <= ISSUE;
              end
            end else if (accept) begin
              // The empty-row cycle that follows the last accept carries the write-back.
              rowBits   <= nextRowBits;
              hitCount  <= hitCount + HITCOUNTBITS'(1);
              outValid  <= nextAny;
              outHit    <= makeHitAddress(row, nextIndex);
              writeBack <= !nextAny && clearLatched && rowHadHit;
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            busy     <= 1'b0;
            outValid <= 1'b0;
            state    <= IDLE;
          end
        endcase
      end
    end
  end

  // An abort arriving in the write-back cycle must not zero the row.
  assign memWriteEnable = writeBack && !abort;
  assign memWriteData   = '0;
  assign memAddress     = row;
  assign outAddress     = outHit;
  assign debugState     = state;

endmodule

// File: tb/tb_hit_address_readout.sv
// Directed bench for hit_address_readout with a behavioural one-cycle-latency bitmap RAM.
module tb_hit_address_readout;
  import hit_address_readout_pkg::*;

  logic        clock = 1'b0;
  logic        resetN = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        clearAfterRead = 1'b0;
  logic        outReady = 1'b0;
  logic        busy, done, memWriteEnable, outValid;
  logic [3:0]  memAddress;
  logic [15:0] memData, memWriteData;
  logic [7:0]  outAddress;
  logic [8:0]  hitCount;
  logic [2:0]  debugState;

  logic [15:0] mem [16];
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          doneCount = 0;
  int          writeCount = 0;
  logic [3:0]  lastWriteAddr = '0;

  hit_address_readout dut (
    .clock(clock), .resetN(resetN), .start(start), .abort(abort),
    .clearAfterRead(clearAfterRead), .busy(busy), .done(done),
    .memAddress(memAddress), .memData(memData), .memWriteEnable(memWriteEnable),
    .memWriteData(memWriteData), .outAddress(outAddress), .outValid(outValid),
    .outReady(outReady), .hitCount(hitCount), .debugState(debugState)
  );

  // ---------------- clock / RAM model / monitor ----------------
  always #5 clock = ~clock;

  always @(posedge clock) begin
    memData <= mem[memAddress];
    if (memWriteEnable) mem[memAddress] = memWriteData;
  end

  always @(negedge clock) begin
    if (resetN) begin
      if (outValid && outReady) got_q.push_back(outAddress);
      if (done) doneCount++;
      if (memWriteEnable) begin
        writeCount++;
        lastWriteAddr = memAddress;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_rows(input logic [15:0] row3, input logic [15:0] row15);
    for (int r = 0; r < 16; r++) mem[r] = '0;
    mem[3]  = row3;
    mem[15] = row15;
  endtask

  task automatic pulse_start(input logic clr);
    start = 1'b1;
    clearAfterRead = clr;
    tick();
    start = 1'b0;
    clearAfterRead = 1'b0;
  endtask

  // cycle is 1 in the first cycle after the start edge.
  task automatic run_to_done(input int budget, output int cycle, output bit timedOut);
    cycle = 1;
    timedOut = 1'b0;
    while (!done) begin
      if (cycle >= budget) begin
        timedOut = 1'b1;
        break;
      end
      tick();
      cycle++;
    end
  endtask

  task automatic wait_for_34(input string name);
    int n = 0;
    while (!(outValid && outAddress == 8'h34) && n < 100) begin
      tick();
      n++;
    end
    vectors++;
    if (n >= 100) begin
      miscompares++;
      $display("FAIL %s wait_for_0x34: not presented within 100 cycles", name);
    end
  endtask

  task automatic set_expected_stream();
    exp_q.delete();
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h34);
    exp_q.push_back(8'h3F);
    exp_q.push_back(8'hF0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetN = 1'b0;
    tick();
    tick();
    vectors++;
    if ({busy, done, outValid, memWriteEnable} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 0000", {busy, done, outValid, memWriteEnable});
    end
    vectors++;
    if ({memAddress, outAddress, hitCount} !== 21'd0) begin
      miscompares++;
      $display("FAIL reset_buses: got memAddress=%h outAddress=%h hitCount=%0d expected all 0",
               memAddress, outAddress, hitCount);
    end
    vectors++;
    if (debugState !== 3'd0 || memWriteData !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_state: got state=%0d writeData=%h expected 0/0000", debugState, memWriteData);
    end
    resetN = 1'b1;
    tick();
  endtask

  task automatic test_empty_scan();
    int cycle;
    bit timedOut;
    load_rows(16'h0000, 16'h0000);
    outReady = 1'b1;
    got_q.delete();
    doneCount = 0;
    pulse_start(1'b0);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL empty_busy: got %b expected 1", busy);
    end
    run_to_done(200, cycle, timedOut);
    vectors++;
    if (timedOut || cycle != 49) begin
      miscompares++;
      $display("FAIL empty_done_cycle: got %0d (timeout=%0d) expected 49", cycle, timedOut);
    end
    tick();
    vectors++;
    if (got_q.size() != 0 || hitCount !== 9'd0) begin
      miscompares++;
      $display("FAIL empty_hits: got %0d emitted hitCount=%0d expected 0/0", got_q.size(), hitCount);
    end
    vectors++;
    if (doneCount != 1 || busy !== 1'b0 || debugState !== 3'd0) begin
      miscompares++;
      $display("FAIL empty_end: got done=%0d busy=%b state=%0d expected 1/0/0", doneCount, busy, debugState);
    end
  endtask

  task automatic test_hit_stream();
    int cycle;
    bit timedOut;
    load_rows(16'h8011, 16'h0001);
    set_expected_stream();
    outReady = 1'b1;
    got_q.delete();
    doneCount = 0;
    pulse_start(1'b0);
    run_to_done(200, cycle, timedOut);
    vectors++;
    if (timedOut || cycle != 53) begin
      miscompares++;
      $display("FAIL stream_done_cycle: got %0d (timeout=%0d) expected 53", cycle, timedOut);
    end
    tick();
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL stream_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL stream_addr[%0d]: got %h expected %h", i,
                 (i < got_q.size()) ? got_q[i] : 8'h00, exp_q[i]);
      end
    end
    vectors++;
    if (hitCount !== 9'd4 || doneCount != 1) begin
      miscompares++;
      $display("FAIL stream_totals: got hitCount=%0d done=%0d expected 4/1", hitCount, doneCount);
    end
  endtask

  task automatic test_backpressure();
    int cycle;
    bit timedOut;
    load_rows(16'h8011, 16'h0001);
    set_expected_stream();
    outReady = 1'b1;
    got_q.delete();
    pulse_start(1'b0);
    wait_for_34("backpressure");
    outReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      tick();
      vectors++;
      if ({outValid, outAddress} !== {1'b1, 8'h34}) begin
        miscompares++;
        $display("FAIL hold[%0d]: got valid=%b addr=%h expected 1/34", i, outValid, outAddress);
      end
    end
    start = 1'b0;
    outReady = 1'b1;
    run_to_done(200, cycle, timedOut);
    tick();
    vectors++;
    if (timedOut || got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL hold_count: got %0d (timeout=%0d) expected %0d", got_q.size(), timedOut, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL hold_addr[%0d]: got %h expected %h", i,
                 (i < got_q.size()) ? got_q[i] : 8'h00, exp_q[i]);
      end
    end
    vectors++;
    if (hitCount !== 9'd4) begin
      miscompares++;
      $display("FAIL hold_hitcount: got %0d expected 4", hitCount);
    end
  endtask

  task automatic test_clear_after_read();
    int cycle;
    bit timedOut;
    load_rows(16'h8011, 16'h0000);
    outReady = 1'b1;
    got_q.delete();
    writeCount = 0;
    pulse_start(1'b1);
    run_to_done(200, cycle, timedOut);
    tick();
    vectors++;
    if (timedOut || writeCount != 1 || lastWriteAddr !== 4'd3) begin
      miscompares++;
      $display("FAIL clear_writes: got %0d writes last addr %0d (timeout=%0d) expected 1 at 3",
               writeCount, lastWriteAddr, timedOut);
    end
    vectors++;
    if (mem[3] !== 16'h0000 || got_q.size() != 3 || hitCount !== 9'd3) begin
      miscompares++;
      $display("FAIL clear_row: got row3=%h emitted=%0d hitCount=%0d expected 0000/3/3",
               mem[3], got_q.size(), hitCount);
    end
    got_q.delete();
    pulse_start(1'b0);
    run_to_done(200, cycle, timedOut);
    tick();
    vectors++;
    if (timedOut || got_q.size() != 0 || hitCount !== 9'd0 || writeCount != 1) begin
      miscompares++;
      $display("FAIL clear_rescan: got emitted=%0d hitCount=%0d writes=%0d expected 0/0/1",
               got_q.size(), hitCount, writeCount);
    end
  endtask

  task automatic test_abort();
    int cycle;
    bit timedOut;
    load_rows(16'h8011, 16'h0001);
    set_expected_stream();
    outReady = 1'b1;
    doneCount = 0;
    pulse_start(1'b0);
    wait_for_34("abort");
    outReady = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vectors++;
    if ({outValid, busy, debugState} !== 5'b00000) begin
      miscompares++;
      $display("FAIL abort_idle: got valid=%b busy=%b state=%0d expected 0/0/0", outValid, busy, debugState);
    end
    vectors++;
    if (hitCount !== 9'd1) begin
      miscompares++;
      $display("FAIL abort_hitcount: got %0d expected 1", hitCount);
    end
    repeat (60) tick();
    vectors++;
    if (doneCount != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_no_done: got done=%0d busy=%b expected 0/0", doneCount, busy);
    end
    outReady = 1'b1;
    got_q.delete();
    pulse_start(1'b0);
    run_to_done(200, cycle, timedOut);
    tick();
    vectors++;
    if (timedOut || got_q.size() != exp_q.size() || hitCount !== 9'd4) begin
      miscompares++;
      $display("FAIL abort_rescan: got emitted=%0d hitCount=%0d (timeout=%0d) expected 4/4",
               got_q.size(), hitCount, timedOut);
    end
    vectors++;
    if (got_q.size() == 0 || got_q[0] !== 8'h30) begin
      miscompares++;
      $display("FAIL abort_first_addr: got %h expected 30", (got_q.size() > 0) ? got_q[0] : 8'h00);
    end
  endtask

  task automatic test_reset_mid_scan();
    int cycle;
    bit timedOut;
    load_rows(16'h8011, 16'h0001);
    outReady = 1'b1;
    pulse_start(1'b0);
    repeat (12) tick();
    resetN = 1'b0;
    start = 1'b1;
    #1;
    vectors++;
    if ({busy, done, outValid, memWriteEnable, memAddress, outAddress, hitCount} !== 25'd0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got busy=%b valid=%b addr=%h hitCount=%0d memAddress=%h expected all 0",
               busy, outValid, outAddress, hitCount, memAddress);
    end
    repeat (3) tick();
    start = 1'b0;
    resetN = 1'b1;
    repeat (3) tick();
    vectors++;
    if (busy !== 1'b0 || debugState !== 3'd0 || hitCount !== 9'd0) begin
      miscompares++;
      $display("FAIL midreset_no_scan: got busy=%b state=%0d hitCount=%0d expected 0/0/0",
               busy, debugState, hitCount);
    end
    got_q.delete();
    doneCount = 0;
    pulse_start(1'b0);
    run_to_done(200, cycle, timedOut);
    vectors++;
    if (timedOut || cycle != 53) begin
      miscompares++;
      $display("FAIL midreset_done_cycle: got %0d (timeout=%0d) expected 53", cycle, timedOut);
    end
    tick();
    vectors++;
    if (got_q.size() != 4 || hitCount !== 9'd4 || doneCount != 1) begin
      miscompares++;
      $display("FAIL midreset_rescan: got emitted=%0d hitCount=%0d done=%0d expected 4/4/1",
               got_q.size(), hitCount, doneCount);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int r = 0; r < 16; r++) mem[r] = '0;
    test_reset();
    test_empty_scan();
    test_hit_stream();
    test_backpressure();
    test_clear_after_read();
    test_abort();
    test_reset_mid_scan();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
